id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//   Parametrised, registered decode stage for the RV32I pipeline.
//   Holds the integer register file with write-back bypass, decodes control/immediate,
//   detects load-use hazards, and presents one decoded instruction per cycle into an
//   ID/EX output register under a valid/ready handshake. Sits between IF/ID and EX.
// PARAMETERS
//   XLEN     32  datapath / register width
//   NREG     32  architectural registers (power of 2, <=32); AW=$clog2(NREG)
//   BYPASS   1   1: same-cycle WB->read forwarding; 0: read old value
// PORTS
//   clock         in   1     rising-edge clock
//   reset         in   1     asynchronous, active-high
//   in_valid      in   1     IF/ID holds an instruction
//   in_ready      out  1     ID accepts inst this cycle
//   inst          in   32    instruction word
//   pc            in   XLEN  PC of inst
//   flush         in   1     kill in-flight ID/EX contents (branch redirect)
//   wb_en         in   1     write-back enable
//   wb_addr       in   5     write-back register
//   wb_data       in   XLEN  write-back data
//   out_valid     out  1     ID/EX register holds a valid instruction
//   out_ready     in   1     EX consumes ID/EX contents
//   out_controls  out  11    {mem_read,mem_write,alu_src,mem_to_reg[1:0],jump[1:0],alu_op[3:0]}
//   out_reg_write out  1     instruction writes rd
//   out_inst_size out  2     memory access size
//   out_reg_a     out  XLEN  rs1 value
//   out_reg_b     out  XLEN  rs2 value
//   out_imm       out  XLEN  sign-extended immediate
//   out_pc        out  XLEN  PC of instruction
//   out_rd        out  5     destination register
//   hazard_stall  out  1     load-use stall asserted this cycle
// BEHAVIOUR
//   Reset: all out_* = 0, out_valid=0, every register file entry = 0.
//   Decode: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
//     Control fields follow the id_control encoding. Immediate is I/S/B/U/J sign-extended
//     per opcode, combinational (no extra cycle).
//   Regfile: NREG x XLEN flops, written at clock edge when wb_en && wb_addr!=0 && wb_addr<NREG.
//     Reads of x0 or addr>=NREG return 0.
//     BYPASS=1: if wb_en && wb_addr==rsN && rsN!=0, the read returns wb_data in the same cycle.
//   Handshake: adv = out_ready | ~out_valid.
//     in_ready = adv & ~hazard_stall & ~flush.
//     Latency 1: an inst accepted at edge N appears on out_* after edge N; held stable
//     while out_valid & ~out_ready.
//   Hazard: hazard_stall = in_valid & out_valid & out_controls[10] & out_rd!=0 &
//     ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
//     uses_rs1 = 0 for LUI/AUIPC/JAL; uses_rs2 = 1 only for R/S/B types.
//   Next-state priority at each edge:
//     1. flush           -> out_valid<=0
//     2. in_valid & in_ready -> load out_*, out_valid<=1
//     3. out_ready       -> out_valid<=0 (bubble; stalled inst stays at input)
//     4. else            -> hold
//   out_* data fields need not change on bubble/flush; verify only when out_valid=1.
//   Regfile writes occur regardless of flush or stall.
//   Reset mid-stall clears out_valid; the pending inst is re-presented by IF.
// TESTING
//   1. Reset, then addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1,
//      out_imm=5, out_rd=1, out_reg_write=1.
//   2. wb_en=1 wb_addr=3 wb_data=0xDEAD same cycle as add x4,x3,x3 -> out_reg_a=out_reg_b=0xDEAD
//      (BYPASS=1); with BYPASS=0 -> old x3.
//   3. lw x5,0(x2) then add x6,x5,x1 back-to-back -> hazard_stall=1 and in_ready=0 for 1 cycle;
//      bubble, then add issues.
//   4. out_ready=0 for 3 cycles with valid output -> out_* stable, in_ready=0; release -> next
//      inst loads.
//   5. flush=1 with in_valid=1 -> out_valid=0 next edge, inst not accepted; wb to x0 ->
//      x0 reads 0.
//   6. Assert reset asynchronously mid-stall -> out_valid=0 immediately, regfile reads 0 after.

Source files
------------

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: register file with write-back bypass, control/immediate decode,
// load-use hazard detection and a valid/ready ID/EX output register.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [10:0]     out_controls,
  output logic            out_reg_write,
  output logic [1:0]      out_inst_size,
  output logic [XLEN-1:0] out_reg_a,
  output logic [XLEN-1:0] out_reg_b,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            hazard_stall
);
  localparam int AW = $clog2(NREG);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic            mem_read, mem_write, alu_src, reg_write, uses_rs1, uses_rs2;
  logic [1:0]      mem_to_reg, jump, inst_size;
  logic [3:0]      alu_op;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x, reg_a, reg_b;
  logic [XLEN-1:0] rf [NREG];
  logic            adv, accept;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREG);
  endfunction

  // alu_op: {inst[30],funct3} for ALU ops, 0000 add for address/link, 1000 compare, 1111 pass imm
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 2'b00;
    jump       = 2'b00;
    alu_op     = 4'b0000;
    reg_write  = 1'b0;
    inst_size  = 2'b00;
    uses_rs1   = 1'b1;
    uses_rs2   = 1'b0;
    imm32      = 32'd0;
    case (opcode)
      OP_LUI: begin
        alu_src = 1'b1; alu_op = 4'b1111; reg_write = 1'b1; uses_rs1 = 1'b0;
        imm32 = {inst[31:12], 12'd0};
      end
      OP_AUIPC: begin
        alu_src = 1'b1; reg_write = 1'b1; uses_rs1 = 1'b0;
        imm32 = {inst[31:12], 12'd0};
      end
      OP_JAL: begin
        alu_src = 1'b1; mem_to_reg = 2'b10; jump = 2'b10; reg_write = 1'b1; uses_rs1 = 1'b0;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        alu_src = 1'b1; mem_to_reg = 2'b10; jump = 2'b11; reg_write = 1'b1;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_BRANCH: begin
        jump = 2'b01; alu_op = 4'b1000; uses_rs2 = 1'b1;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LOAD: begin
        mem_read = 1'b1; alu_src = 1'b1; mem_to_reg = 2'b01; reg_write = 1'b1;
        inst_size = funct3[1:0];
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        mem_write = 1'b1; alu_src = 1'b1; uses_rs2 = 1'b1; inst_size = funct3[1:0];
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_IMM: begin
        alu_src = 1'b1; reg_write = 1'b1;
        alu_op = {(funct3 == 3'b101) & inst[30], funct3};
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_OP: begin
        reg_write = 1'b1; uses_rs2 = 1'b1; alu_op = {inst[30], funct3};
      end
      default: ;
    endcase
  end

  assign imm_x = XLEN'($signed(imm32));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && addr_ok(wb_addr)) begin
      rf[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  always_comb begin
    reg_a = '0;
    if (addr_ok(rs1)) begin
      if (BYPASS && wb_en && (wb_addr == rs1)) reg_a = wb_data;
      else                                      reg_a = rf[rs1[AW-1:0]];
    end
  end

  always_comb begin
    reg_b = '0;
    if (addr_ok(rs2)) begin
      if (BYPASS && wb_en && (wb_addr == rs2)) reg_b = wb_data;
      else                                      reg_b = rf[rs2[AW-1:0]];
    end
  end

  assign hazard_stall = in_valid & out_valid & out_controls[10] & (out_rd != 5'd0) &
                        ((uses_rs1 & (rs1 == out_rd)) | (uses_rs2 & (rs2 == out_rd)));

  // A transfer happens on an edge where valid and ready are both high; the ID/EX register
  // frees when EX takes it or when it is empty, and a loaded entry holds until out_ready.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & ~hazard_stall & ~flush;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_controls  <= '0;
      out_reg_write <= 1'b0;
      out_inst_size <= '0;
      out_reg_a     <= '0;
      out_reg_b     <= '0;
      out_imm       <= '0;
      out_pc        <= '0;
      out_rd        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_controls  <= {mem_read, mem_write, alu_src, mem_to_reg, jump, alu_op};
      out_reg_write <= reg_write;
      out_inst_size <= inst_size;
      out_reg_a     <= reg_a;
      out_reg_b     <= reg_b;
      out_imm       <= imm_x;
      out_pc        <= pc;
      out_rd        <= rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: scenario tasks drive the stage, push expected ID/EX contents
// into a queue and pop/compare them when the output register presents them.
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int W    = 11 + 1 + 2 + 4 * XLEN + 5;
  localparam logic [31:0] B2B_INST [6] = '{32'hFFF08513, 32'h80000597, 32'hFE208CE3,
                                           32'h010000EF, 32'h00318233, 32'h00112423};
  localparam logic [10:0] B2B_CTRL [6] = '{11'h100, 11'h100, 11'h018, 11'h1A0, 11'h000, 11'h300};
  localparam logic        B2B_RW   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [1:0]  B2B_SIZE [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
  localparam logic [31:0] B2B_IMM  [6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF8,
                                           32'h00000010, 32'h00000000, 32'h00000008};

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [31:0]     inst = '0;
  logic [XLEN-1:0] pc = '0;
  logic            flush = 1'b0;
  logic            wb_en = 1'b0;
  logic [4:0]      wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_ready = 1'b1;

  logic            in_ready, out_valid, out_reg_write, hazard_stall;
  logic [10:0]     out_controls;
  logic [1:0]      out_inst_size;
  logic [XLEN-1:0] out_reg_a, out_reg_b, out_imm, out_pc;
  logic [4:0]      out_rd;
  logic            nb_in_ready, nb_out_valid, nb_out_reg_write, nb_hazard_stall;
  logic [10:0]     nb_out_controls;
  logic [1:0]      nb_out_inst_size;
  logic [XLEN-1:0] nb_out_reg_a, nb_out_reg_b, nb_out_imm, nb_out_pc;
  logic [4:0]      nb_out_rd;

  logic [W-1:0]    obs, nb_obs, exp_v;
  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] rf_m [32];
  int              total = 0;
  int              bad = 0;

  always #5 clock = ~clock;

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .pc(pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_controls(out_controls),
    .out_reg_write(out_reg_write), .out_inst_size(out_inst_size), .out_reg_a(out_reg_a),
    .out_reg_b(out_reg_b), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd),
    .hazard_stall(hazard_stall)
  );

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(nb_in_ready), .inst(inst),
    .pc(pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(nb_out_valid), .out_ready(out_ready), .out_controls(nb_out_controls),
    .out_reg_write(nb_out_reg_write), .out_inst_size(nb_out_inst_size),
    .out_reg_a(nb_out_reg_a), .out_reg_b(nb_out_reg_b), .out_imm(nb_out_imm),
    .out_pc(nb_out_pc), .out_rd(nb_out_rd), .hazard_stall(nb_hazard_stall)
  );

  assign obs    = {out_controls, out_reg_write, out_inst_size, out_reg_a, out_reg_b,
                   out_imm, out_pc, out_rd};
  assign nb_obs = {nb_out_controls, nb_out_reg_write, nb_out_inst_size, nb_out_reg_a,
                   nb_out_reg_b, nb_out_imm, nb_out_pc, nb_out_rd};

  function automatic logic [W-1:0] mk(input logic [10:0] c, input logic rw,
                                      input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm,
                                      input logic [31:0] p, input logic [4:0] rd);
    return {c, rw, sz, a, b, imm, p, rd};
  endfunction

  function automatic logic [31:0] rf_rd(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : rf_m[r];
  endfunction

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(negedge clock);
    wb_en = 1'b0;
    if (addr != 5'd0) rf_m[addr] = data;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_fields: got %h want 0", obs); end
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", hazard_stall); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_addi();
    @(negedge clock);
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'h00500093; pc = 32'h100;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_accept: got %b want 1", in_ready); end
    exp_q.push_back(mk(11'h100, 1'b1, 2'd0, 32'd0, rf_rd(5'd5), 32'd5, 32'h100, 5'd1));
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL addi_out: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_bypass();
    wb_write(5'd3, 32'h1111);
    @(negedge clock);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
    in_valid = 1'b1; inst = 32'h00318233; pc = 32'h200;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL byp_accept: got %b want 1", in_ready); end
    exp_q.push_back(mk(11'h000, 1'b1, 2'd0, 32'hDEAD, 32'hDEAD, 32'd0, 32'h200, 5'd4));
    @(negedge clock);
    wb_en = 1'b0; in_valid = 1'b0; rf_m[3] = 32'hDEAD;
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL byp_out: got %h want %h", obs, exp_v); end
    exp_v = mk(11'h000, 1'b1, 2'd0, 32'h1111, 32'h1111, 32'd0, 32'h200, 5'd4);
    total++; if (nb_obs !== exp_v) begin bad++; $display("FAIL nobyp_out: got %h want %h", nb_obs, exp_v); end
    total++; if (nb_out_valid !== 1'b1) begin bad++; $display("FAIL nobyp_valid: got %b want 1", nb_out_valid); end
    @(negedge clock);
    in_valid = 1'b1; pc = 32'h204;
    #1;
    exp_q.push_back(mk(11'h000, 1'b1, 2'd0, 32'hDEAD, 32'hDEAD, 32'd0, 32'h204, 5'd4));
    @(negedge clock);
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL byp_after_write: got %h want %h", obs, exp_v); end
    total++; if (nb_out_reg_a !== 32'hDEAD) begin bad++; $display("FAIL nobyp_after_write: got %h want dead", nb_out_reg_a); end
  endtask

  task automatic test_load_use();
    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h2000);
    wb_write(5'd5, 32'h55);
    @(negedge clock);
    in_valid = 1'b1; inst = 32'h00012283; pc = 32'h300;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_lw_accept: got %b want 1", in_ready); end
    exp_q.push_back(mk(11'h540, 1'b1, 2'd2, rf_rd(5'd2), 32'd0, 32'd0, 32'h300, 5'd5));
    @(negedge clock);
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL lu_lw_out: got %h want %h", obs, exp_v); end
    inst = 32'h00128333; pc = 32'h304;
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", hazard_stall); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_in_ready: got %b want 0", in_ready); end
    @(negedge clock);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
    #1;
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_stall_clear: got %b want 0", hazard_stall); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_add_accept: got %b want 1", in_ready); end
    exp_q.push_back(mk(11'h000, 1'b1, 2'd0, rf_rd(5'd5), rf_rd(5'd1), 32'd0, 32'h304, 5'd6));
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lu_add_valid: got %b want 1", out_valid); end
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL lu_add_out: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_no_false_stall();
    logic [31:0] ld [2];
    logic [31:0] nx [2];
    logic [W-1:0] ld_e [2];
    logic [W-1:0] nx_e [2];
    ld[0] = 32'h00012283; nx[0] = 32'h00500093;
    ld[1] = 32'h00012403; nx[1] = 32'h123454B7;
    ld_e[0] = mk(11'h540, 1'b1, 2'd2, rf_rd(5'd2), 32'd0, 32'd0, 32'h380, 5'd5);
    nx_e[0] = mk(11'h100, 1'b1, 2'd0, 32'd0, rf_rd(5'd5), 32'd5, 32'h384, 5'd1);
    ld_e[1] = mk(11'h540, 1'b1, 2'd2, rf_rd(5'd2), 32'd0, 32'd0, 32'h390, 5'd8);
    nx_e[1] = mk(11'h10F, 1'b1, 2'd0, rf_rd(5'd8), rf_rd(5'd3), 32'h12345000, 32'h394, 5'd9);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_valid = 1'b1; inst = ld[k]; pc = 32'h380 + 32'(k) * 32'h10;
      #1;
      exp_q.push_back(ld_e[k]);
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL nfs_load%0d: got %h want %h", k, obs, exp_v); end
      inst = nx[k]; pc = 32'h384 + 32'(k) * 32'h10;
      #1;
      total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL nfs_stall%0d: got %b want 0", k, hazard_stall); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nfs_ready%0d: got %b want 1", k, in_ready); end
      exp_q.push_back(nx_e[k]);
      @(negedge clock);
      in_valid = 1'b0;
      exp_v = exp_q.pop_front();
      total++; if (obs !== exp_v) begin bad++; $display("FAIL nfs_next%0d: got %h want %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00112423; pc = 32'h400;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_sw_accept: got %b want 1", in_ready); end
    exp_q.push_back(mk(11'h300, 1'b0, 2'd2, rf_rd(5'd2), rf_rd(5'd1), 32'd8, 32'h400, 5'd8));
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      inst = 32'h123454B7; pc = 32'h404;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", i, out_valid); end
      total++; if (obs !== exp_q[0]) begin bad++; $display("FAIL bp_stable%0d: got %h want %h", i, obs, exp_q[0]); end
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", in_ready); end
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL bp_sw_out: got %h want %h", obs, exp_v); end
    exp_q.push_back(mk(11'h10F, 1'b1, 2'd0, rf_rd(5'd8), rf_rd(5'd3), 32'h12345000, 32'h404, 5'd9));
    @(negedge clock);
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL bp_lui_out: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_flush();
    @(negedge clock);
    out_ready = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF;
    in_valid = 1'b1; inst = 32'h000003B3; pc = 32'h500;
    #1;
    exp_q.push_back(mk(11'h000, 1'b1, 2'd0, 32'd0, 32'd0, 32'd0, 32'h500, 5'd7));
    @(negedge clock);
    wb_en = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL fl_x0_bypass: got %h want %h", obs, exp_v); end
    flush = 1'b1; inst = 32'h010000EF; pc = 32'h504;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready: got %b want 0", in_ready); end
    @(negedge clock);
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_kill: got %b want 0", out_valid); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_reaccept: got %b want 1", in_ready); end
    exp_q.push_back(mk(11'h1A0, 1'b1, 2'd0, 32'd0, rf_rd(5'd16), 32'h10, 32'h504, 5'd1));
    @(negedge clock);
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL fl_jal_out: got %h want %h", obs, exp_v); end
    @(negedge clock);
    in_valid = 1'b1; inst = 32'h000003B3; pc = 32'h508;
    #1;
    exp_q.push_back(mk(11'h000, 1'b1, 2'd0, 32'd0, 32'd0, 32'd0, 32'h508, 5'd7));
    @(negedge clock);
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL fl_x0_read: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int cyc = 0;
    while ((idx < 6 || exp_q.size() != 0) && cyc < 200) begin
      @(negedge clock);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got %h want none", obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin bad++; $display("FAIL b2b_out: got %h want %h", obs, exp_v); end
        end
      end
      if (idx < 6) begin
        in_valid = 1'b1; inst = B2B_INST[idx]; pc = 32'h600 + 32'(idx) * 32'd4;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(mk(B2B_CTRL[idx], B2B_RW[idx], B2B_SIZE[idx], rf_rd(inst[19:15]),
                           rf_rd(inst[24:20]), B2B_IMM[idx], pc, inst[11:7]));
        idx++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (idx != 6 || exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got issued=%0d left=%0d want 6/0", idx, exp_q.size()); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00012283; pc = 32'h700;
    #1;
    exp_q.push_back(mk(11'h540, 1'b1, 2'd2, rf_rd(5'd2), 32'd0, 32'd0, 32'h700, 5'd5));
    @(negedge clock);
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL ar_lw_out: got %h want %h", obs, exp_v); end
    inst = 32'h00128333; pc = 32'h704;
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL ar_stall: got %b want 1", hazard_stall); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL ar_stall_clear: got %b want 0", hazard_stall); end
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_reaccept: got %b want 1", in_ready); end
    exp_q.push_back(mk(11'h000, 1'b1, 2'd0, rf_rd(5'd5), rf_rd(5'd1), 32'd0, 32'h704, 5'd6));
    @(negedge clock);
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    total++; if (obs !== exp_v) begin bad++; $display("FAIL ar_rf_cleared: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_no_false_stall();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
